// File: rtl/cfg_pwm_timer.sv
// Two-channel PWM timer driven by the packed config bus.
// Prescaled up-counter, shadowed period/duty, one-shot or continuous.
module cfg_pwm_timer #(
    parameter int REG_WIDTH  = 8,
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    output logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic [1:0]                       pwm_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  wrap_q, wrap_d;
    logic [7:0]  per_q, per_d;
    logic [7:0]  dty0_q, dty0_d;
    logic [7:0]  dty1_q, dty1_d;
    logic [3:0]  psc_q, psc_d;
    logic [15:0] pre_q, pre_d;
    logic [15:0] pre_top;
    logic        clr_q;
    logic        seen_q, seen_d;
    logic        tick, wrap, clr_rise;
    logic [1:0]  raw;
    logic [7:0]  st0_q, st1_q, st2_q, st3_q;
    logic        cfg_unused;

    logic       en, oneshot;
    logic [1:0] inv;
    logic [3:0] psc_cfg;
    logic [7:0] per_cfg, dty0_cfg, dty1_cfg;
    logic       clr_cmd;

    assign en       = config_regs[0];
    assign oneshot  = config_regs[1];
    assign inv      = config_regs[3:2];
    assign psc_cfg  = config_regs[7:4];
    assign per_cfg  = config_regs[15:8];
    assign dty0_cfg = config_regs[23:16];
    assign dty1_cfg = config_regs[31:24];
    assign clr_cmd  = config_regs[32];

    // Bytes past CMD and CMD[7:1] carry nothing for this block.
    assign cfg_unused = ^config_regs;

    assign pre_top  = (16'd1 << psc_q) - 16'd1;
    assign clr_rise = clr_cmd & ~clr_q;

    // Channel compare; only meaningful while the counter is running.
    always_comb begin
        raw[0] = (state_q == RUN) && (cnt_q < dty0_q);
        raw[1] = (state_q == RUN) && (cnt_q < dty1_q);
    end

    // Next-state, counter, prescaler, shadow and wrap-count logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        per_d   = per_q;
        dty0_d  = dty0_q;
        dty1_d  = dty1_q;
        psc_d   = psc_q;
        seen_d  = seen_q | en;
        tick    = 1'b0;
        wrap    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (en) begin
                    per_d   = per_cfg;
                    dty0_d  = dty0_cfg;
                    dty1_d  = dty1_cfg;
                    psc_d   = psc_cfg;
                    pre_d   = 16'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    pre_d   = 16'd0;
                end else begin
                    tick = (pre_q == pre_top);
                    if (tick) begin
                        pre_d = 16'd0;
                        if (cnt_q == per_q) begin
                            cnt_d  = 8'd0;
                            wrap   = 1'b1;
                            per_d  = per_cfg;
                            dty0_d = dty0_cfg;
                            dty1_d = dty1_cfg;
                            psc_d  = psc_cfg;
                            if (oneshot) state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        pre_d = pre_q + 16'd1;
                    end
                end
            end
            DONE: begin
                cnt_d = 8'd0;
                if (!en) begin
                    state_d = IDLE;
                    pre_d   = 16'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        wrap_d = clr_rise ? 8'd0 : wrap_q + {7'd0, wrap};
    end

    // State, outputs and status mirror; ena low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            pre_q   <= 16'd0;
            wrap_q  <= 8'd0;
            per_q   <= 8'd0;
            dty0_q  <= 8'd0;
            dty1_q  <= 8'd0;
            psc_q   <= 4'd0;
            clr_q   <= 1'b0;
            seen_q  <= 1'b0;
            pwm_out <= 2'b00;
            st0_q   <= 8'd0;
            st1_q   <= 8'd0;
            st2_q   <= 8'd0;
            st3_q   <= 8'd0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
            per_q   <= per_d;
            dty0_q  <= dty0_d;
            dty1_q  <= dty1_d;
            psc_q   <= psc_d;
            clr_q   <= clr_cmd;
            seen_q  <= seen_d;
            pwm_out <= raw ^ inv;
            st0_q   <= cnt_d;
            st1_q   <= wrap_d;
            st2_q   <= {5'd0, seen_d, state_d == DONE, state_d == RUN};
            st3_q   <= per_d;
        end
    end

    // Pack status bytes; st4 and above read as zero.
    always_comb begin
        status_regs        = '0;
        status_regs[31:0]  = {st3_q, st2_q, st1_q, st0_q};
    end

endmodule
